inst_fetch_unit: RTL and testbench
==================================

// Module: inst_fetch_unit
// PURPOSE
//  Instruction-fetch front end; the producer side of the decode interface (inst/pc in, pause/newPC back).
//  Fetches words from instruction memory over a req/ack handshake into a small instruction buffer.
//  Presents {pc, inst} with a valid flag to decode. Honours the decode stall (pause) and taken-branch redirects.
// PARAMETERS
//  RESET_PC    32'h0000_0000  first fetch address after reset
//  BUF_DEPTH   2              instruction buffer entries (power of 2, >=2)
// PORTS
//  clk          in   1   clock, rising edge
//  rst          in   1   asynchronous reset, active-high
//  imem_req     out  1   fetch request valid
//  imem_addr    out  32  word-aligned fetch address, stable while imem_req=1
//  imem_ack     in   1   response valid; imem_rdata is valid this cycle; legal only while imem_req=1
//  imem_rdata   in   32  fetched instruction word
//  pause        in   1   decode stall: hold current output, no pop
//  redirect     in   1   taken branch/jump from decode, single-cycle pulse
//  redirect_pc  in   32  target; bits [1:0] forced to 2'b00
//  valid_o      out  1   inst_o/pc_o hold a real instruction
//  inst_o       out  32  instruction at buffer head; 32'h0 (NOP) when !valid_o
//  pc_o         out  32  address of inst_o; 32'h0 when !valid_o
// BEHAVIOUR
//  Reset (async): fetch_pc=RESET_PC, buffer empty, state IDLE; imem_req=0, valid_o=0, inst_o=0, pc_o=0.
//  FSM states:
//   IDLE: imem_req=0. Go to REQ when count+0 < BUF_DEPTH.
//   REQ: imem_req=1, imem_addr=fetch_pc.
//   DROP: imem_req=1, imem_addr=stale address; response is discarded.
//  REQ transitions:
//   ack & !redirect: push {fetch_pc, imem_rdata}; fetch_pc+=4.
//     Then stay in REQ if the buffer has room after this cycle's push/pop, else go to IDLE.
//   redirect & !ack: fetch_pc=redirect_pc; go to DROP.
//   redirect & ack: data dropped; fetch_pc=redirect_pc; go to REQ (new address next cycle).
//  DROP transitions: on ack, drop the data, go to REQ with fetch_pc.
//   A further redirect while in DROP overwrites fetch_pc and stays in DROP.
//  At most one outstanding request. imem_addr never changes while req=1 and ack=0.
//  Zero-wait memory (ack in the same cycle as req) sustains 1 instruction/cycle.
//  Pop: valid_o & !pause pops the head at the clock edge. Push and pop in the same cycle: count unchanged.
//  Full: no new request issued. Pending ack with full buffer is impossible by construction (count reserve).
//  Redirect: flushes the whole buffer in the same edge (valid_o=0 next cycle).
//   Redirect has priority over pop and push. The first redirected instruction appears >=1 cycle after its ack.
//  pause & redirect together: redirect wins.
//  fetch_pc wraps 32'hFFFF_FFFC -> 32'h0 silently.
//  Output is a registered buffer head; latency from ack to valid_o is 1 cycle.
// STRUCTURE
//  Shared header:
//   FSM state encodings (IDLE=2'd0, REQ=2'd1, DROP=2'd2)
//   NOP word 32'h0
//   default RESET_PC
//  Sub-module fetch_buf: BUF_DEPTH x 64-bit synchronous FIFO with push/pop/flush, count, full/empty, async reset.
//  Top level holds the FSM, fetch_pc register, and output gating.
// TESTING
//  1. Reset, then zero-wait memory returning addr+1.
//     -> req high the first cycle; valid_o at cycle 2; pc_o 0,4,8… one per cycle; inst_o=pc_o+1.
//  2. ack delayed 3 cycles per request.
//     -> imem_addr stable across wait; valid_o toggles; no duplicated or skipped pc.
//  3. pause held 5 cycles with fast memory.
//     -> buffer fills to 2, imem_req=0, pc_o/inst_o frozen; release resumes at next pc with no loss.
//  4. redirect to 32'h100 while a request is outstanding (ack 2 cycles later).
//     -> stale data dropped; next valid_o shows pc_o=32'h100.
//  5. redirect with ack in the same cycle, redirect_pc=32'h203.
//     -> that ack's data dropped; next fetch addr 32'h200; buffer flushed.
//  6. rst asserted mid-DROP.
//     -> all outputs zero immediately; req restarts at RESET_PC after rst release.

Source files
------------

// File: rtl/inst_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch front end.
package inst_fetch_unit_pkg;

    // Fetch FSM: IDLE waits for buffer room, REQ has a live request for
    // fetch_pc, DROP waits out a request made stale by a redirect.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_WORD         = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'h0000_0004;

    // One buffer entry: the fetch address and the word returned for it.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } buf_entry_t;

    // Branch targets are word addresses; low two bits are ignored.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/inst_fetch_unit_fetch_buf.sv
// Small synchronous FIFO holding fetched {pc, inst} entries.
// Flush empties the buffer at the clock edge and wins over push/pop.
module fetch_buf #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic [CW-1:0]    count_next_s;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == CW'(0));
    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;
    assign rdata     = mem_r[rd_ptr_r];
    assign count     = count_r;

    // Occupancy after this cycle's push/pop (flush handled in the register).
    always_comb begin
        count_next_s = count_r;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_next_s = count_r + CW'(1);
            2'b01:   count_next_s = count_r - CW'(1);
            default: count_next_s = count_r;
        endcase
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= CW'(0);
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (flush) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= CW'(0);
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= wdata;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r <= count_next_s;
        end
    end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction-fetch front end: issues one request at a time to instruction
// memory, buffers returned words with their pc, and presents the buffer
// head to decode. Handles decode stall (pause) and branch redirects.
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        pause,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o
);

    localparam int CW = $clog2(BUF_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);

    fetch_state_e  state_r;
    fetch_state_e  state_next_s;
    logic [31:0]   fetch_pc_r;
    logic [31:0]   fetch_pc_next_s;
    logic [31:0]   stale_addr_r;
    logic [31:0]   stale_addr_next_s;
    logic          push_s;
    logic          pop_s;
    logic          flush_s;
    logic [CW-1:0] count_s;
    logic [CW-1:0] count_after_push_s;
    logic          full_s;
    logic          empty_s;
    buf_entry_t    wr_entry_s;
    buf_entry_t    head_s;

    assign wr_entry_s = '{pc: fetch_pc_r, inst: imem_rdata};

    fetch_buf #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (64)
    ) u_fetch_buf (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .flush (flush_s),
        .wdata (wr_entry_s),
        .rdata (head_s),
        .count (count_s),
        .full  (full_s),
        .empty (empty_s)
    );

    // A redirect flushes and suppresses any pop; full is implied by the
    // count reserve so push never meets a full buffer.
    assign flush_s            = redirect;
    assign pop_s              = ~empty_s & ~pause & ~redirect;
    assign count_after_push_s = count_s + CW'(1) - (pop_s ? CW'(1) : CW'(0));

    // Next-state, fetch address and buffer push decisions.
    always_comb begin
        state_next_s      = state_r;
        fetch_pc_next_s   = fetch_pc_r;
        stale_addr_next_s = stale_addr_r;
        push_s            = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (redirect) begin
                    fetch_pc_next_s = word_align(redirect_pc);
                    state_next_s    = ST_REQ;
                end else if (count_s < DEPTH_C) begin
                    state_next_s = ST_REQ;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (redirect) begin
                    fetch_pc_next_s = word_align(redirect_pc);
                    if (imem_ack) begin
                        state_next_s = ST_REQ;
                    end else begin
                        // Request still in flight: remember its address so
                        // the bus stays stable until it completes.
                        stale_addr_next_s = fetch_pc_r;
                        state_next_s      = ST_DROP;
                    end
                end else if (imem_ack) begin
                    push_s          = 1'b1;
                    fetch_pc_next_s = fetch_pc_r + PC_STEP;
                    if (count_after_push_s < DEPTH_C) begin
                        state_next_s = ST_REQ;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end else begin
                    state_next_s = ST_REQ;
                end
            end
            ST_DROP: begin
                if (redirect) begin
                    fetch_pc_next_s = word_align(redirect_pc);
                    if (imem_ack) begin
                        state_next_s = ST_REQ;
                    end else begin
                        state_next_s = ST_DROP;
                    end
                end else if (imem_ack) begin
                    state_next_s = ST_REQ;
                end else begin
                    state_next_s = ST_DROP;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // FSM state, fetch pointer and stale-request address registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            fetch_pc_r   <= RESET_PC;
            stale_addr_r <= RESET_PC;
        end else begin
            state_r      <= state_next_s;
            fetch_pc_r   <= fetch_pc_next_s;
            stale_addr_r <= stale_addr_next_s;
        end
    end

    // Bus and decode outputs are decoded from registered state only.
    assign imem_req  = (state_r == ST_REQ) || (state_r == ST_DROP);
    assign imem_addr = (state_r == ST_DROP) ? stale_addr_r : fetch_pc_r;
    assign valid_o   = ~empty_s;
    assign inst_o    = empty_s ? NOP_WORD : head_s.inst;
    assign pc_o      = empty_s ? NOP_WORD : head_s.pc;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: a hand-derived vector table,
// directed multi-cycle sequences and randomized traffic against a
// transaction-level reference model.
module tb_inst_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        pause = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        valid_o;
    logic [31:0] inst_o;
    logic [31:0] pc_o;

    int checks = 0;
    int errors = 0;

    inst_fetch_unit #(
        .RESET_PC  (RESET_PC),
        .BUF_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .pause       (pause),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .valid_o     (valid_o),
        .inst_o      (inst_o),
        .pc_o        (pc_o)
    );

    always #5 clk = ~clk;

    // Memory contents: each word is its own address plus one.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a + 32'd1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // busy: a request is on the bus; discard: its reply must be thrown away.
    bit          m_busy;
    bit          m_discard;
    logic [31:0] m_req_addr;
    logic [31:0] m_fetch_pc;
    logic [63:0] m_q[$];

    task automatic model_reset();
        m_busy     = 1'b0;
        m_discard  = 1'b0;
        m_req_addr = RESET_PC;
        m_fetch_pc = RESET_PC;
        m_q.delete();
    endtask

    task automatic model_edge(input bit ack, input bit pz, input bit rd,
                              input logic [31:0] tgt, input logic [31:0] rdata);
        bit popping;
        int cnt;
        popping = (m_q.size() > 0) && !pz && !rd;
        if (rd) begin
            m_q.delete();
            m_fetch_pc = {tgt[31:2], 2'b00};
            if (m_busy && !ack) begin
                m_discard = 1'b1;
            end else begin
                m_busy     = 1'b1;
                m_discard  = 1'b0;
                m_req_addr = m_fetch_pc;
            end
        end else if (m_busy) begin
            if (ack) begin
                if (!m_discard) begin
                    m_q.push_back({m_req_addr, rdata});
                    m_fetch_pc = m_fetch_pc + 32'd4;
                end
                if (popping) void'(m_q.pop_front());
                m_busy     = m_discard || (m_q.size() < DEPTH);
                m_discard  = 1'b0;
                m_req_addr = m_fetch_pc;
            end else if (popping) begin
                void'(m_q.pop_front());
            end
        end else begin
            cnt = m_q.size();
            if (popping) void'(m_q.pop_front());
            m_busy     = (cnt < DEPTH);
            m_req_addr = m_fetch_pc;
        end
    endtask

    task automatic check_model(input string tag);
        logic [63:0] head;
        chk({tag, ".req"}, {31'b0, imem_req}, {31'b0, m_busy});
        if (m_busy) chk({tag, ".addr"}, imem_addr, m_req_addr);
        chk({tag, ".valid"}, {31'b0, valid_o}, {31'b0, (m_q.size() > 0)});
        head = (m_q.size() > 0) ? m_q[0] : 64'h0;
        chk({tag, ".pc"}, pc_o, head[63:32]);
        chk({tag, ".inst"}, inst_o, head[31:0]);
    endtask

    // One cycle: check outputs at the negedge, drive inputs, advance the model.
    task automatic step(input bit ack_i, input bit pz, input bit rd, input logic [31:0] tgt,
                        input string tag);
        bit a;
        check_model(tag);
        a           = ack_i && m_busy;
        imem_ack    = a;
        pause       = pz;
        redirect    = rd;
        redirect_pc = tgt;
        imem_rdata  = mem_word(imem_addr);
        model_edge(a, pz, rd, tgt, mem_word(m_req_addr));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        imem_ack = 1'b0; pause = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit          ack;
        bit          pz;
        bit          rd;
        logic [31:0] tgt;
        bit          e_req;
        logic [31:0] e_addr;
        bit          e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
    } vec_t;

    function automatic vec_t mk(bit a, bit p, bit r, logic [31:0] t, bit q,
                                logic [31:0] ad, bit v, logic [31:0] pc, logic [31:0] in);
        vec_t x;
        x.ack = a; x.pz = p; x.rd = r; x.tgt = t; x.e_req = q;
        x.e_addr = ad; x.e_valid = v; x.e_pc = pc; x.e_inst = in;
        return x;
    endfunction

    vec_t tbl[15];

    initial begin
        int wait_cnt;
        bit a, pz, rd;
        logic [31:0] tgt;

        // Expected outputs are sampled before the row's inputs are applied.
        tbl[0]  = mk(1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   32'h0);
        tbl[1]  = mk(1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h0,   1'b0, 32'h0,   32'h0);
        tbl[2]  = mk(1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h4,   1'b1, 32'h0,   32'h1);
        tbl[3]  = mk(1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h8,   1'b1, 32'h4,   32'h5);
        tbl[4]  = mk(1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h4,   32'h5);
        tbl[5]  = mk(1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h4,   32'h5);
        tbl[6]  = mk(1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h8,   32'h9);
        tbl[7]  = mk(1'b1, 1'b0, 1'b1, 32'h203, 1'b1, 32'hC,   1'b0, 32'h0,   32'h0);
        tbl[8]  = mk(1'b0, 1'b0, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h0,   32'h0);
        tbl[9]  = mk(1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h200, 1'b0, 32'h0,   32'h0);
        tbl[10] = mk(1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h200, 1'b0, 32'h0,   32'h0);
        tbl[11] = mk(1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 32'h0,   32'h0);
        tbl[12] = mk(1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h104, 1'b1, 32'h100, 32'h101);
        tbl[13] = mk(1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h104, 1'b0, 32'h0,   32'h0);
        tbl[14] = mk(1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h108, 1'b1, 32'h104, 32'h105);

        do_reset();
        for (int i = 0; i < 15; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            chk({tag, ".req"}, {31'b0, imem_req}, {31'b0, tbl[i].e_req});
            if (tbl[i].e_req) chk({tag, ".addr"}, imem_addr, tbl[i].e_addr);
            chk({tag, ".valid"}, {31'b0, valid_o}, {31'b0, tbl[i].e_valid});
            chk({tag, ".pc"}, pc_o, tbl[i].e_pc);
            chk({tag, ".inst"}, inst_o, tbl[i].e_inst);
            imem_ack    = tbl[i].ack;
            pause       = tbl[i].pz;
            redirect    = tbl[i].rd;
            redirect_pc = tbl[i].tgt;
            imem_rdata  = mem_word(imem_addr);
            @(posedge clk);
            @(negedge clk);
        end

        // Model-checked directed sequences.
        do_reset();
        model_reset();
        // Memory answering three cycles late.
        for (int r = 0; r < 4; r++) begin
            repeat (3) step(1'b0, 1'b0, 1'b0, 32'h0, "slow");
            step(1'b1, 1'b0, 1'b0, 32'h0, "slow");
        end
        // Decode stall with fast memory, then release.
        repeat (5) step(1'b1, 1'b1, 1'b0, 32'h0, "pause");
        repeat (6) step(1'b1, 1'b0, 1'b0, 32'h0, "resume");
        // Redirect while a request is outstanding; reply two cycles later.
        step(1'b0, 1'b0, 1'b1, 32'h100, "redir_out");
        step(1'b0, 1'b0, 1'b0, 32'h0, "redir_out");
        repeat (4) step(1'b1, 1'b0, 1'b0, 32'h0, "redir_out");
        // Address wrap at the top of memory.
        step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFF8, "wrap");
        repeat (5) step(1'b1, 1'b0, 1'b0, 32'h0, "wrap");
        // Reset arriving while a stale reply is pending.
        step(1'b0, 1'b0, 1'b0, 32'h0, "pre_drop");
        step(1'b0, 1'b0, 1'b1, 32'h300, "pre_drop");
        step(1'b0, 1'b0, 1'b0, 32'h0, "drop");
        chk("drop.addr_stale", {31'b0, imem_req}, 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst.req", {31'b0, imem_req}, 32'h0);
        chk("async_rst.valid", {31'b0, valid_o}, 32'h0);
        chk("async_rst.pc", pc_o, 32'h0);
        chk("async_rst.inst", inst_o, 32'h0);
        imem_ack = 1'b0; redirect = 1'b0; pause = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (5) step(1'b1, 1'b0, 1'b0, 32'h0, "restart");

        // Randomized traffic with variable memory latency.
        wait_cnt = 0;
        for (int c = 0; c < 3000; c++) begin
            a = 1'b0;
            if (m_busy) begin
                if (wait_cnt == 0) begin
                    a        = 1'b1;
                    wait_cnt = $urandom_range(0, 3);
                end else begin
                    wait_cnt--;
                end
            end
            pz  = ($urandom_range(0, 3) == 0);
            rd  = ($urandom_range(0, 19) == 0);
            tgt = $urandom;
            if ($urandom_range(0, 4) == 0) tgt = 32'hFFFF_FFF0 | (tgt & 32'hF);
            step(a, pz, rd, tgt, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
